ex_mem_reg: RTL and testbench

// EX/MEM pipeline register feeding the memory stage: captures execute results and control each cycle.

---
 rtl/ex_mem_reg_pkg.sv | 39 +++
 rtl/ex_mem_reg_if.sv | 32 +++
 rtl/ex_mem_reg_stall_watchdog.sv | 38 +++
 rtl/ex_mem_reg.sv | 111 +++++++++++
 tb/tb_ex_mem_reg.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_reg_pkg.sv
// Shared types for the EX/MEM pipeline register: slot state, control bundle and the
// bubble encoding used whenever an instruction is squashed.
package ex_mem_reg_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic RegWrite;
        logic DMemWrite;
        logic DMemEn;
        logic MemToReg;
        logic DMemDump;
        logic Valid;
    } ctrl_t;

    typedef struct packed {
        ctrl_t             ctrl;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] rt_data;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] rd_addr;
    } slot_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    // A valid dump sitting in the register retires on the next edge the memory stage accepts.
    function automatic logic is_valid_dump(input slot_t s);
        return s.ctrl.Valid & s.ctrl.DMemDump;
    endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// Execute-to-memory bus. slave = the pipeline register, master = whoever drives execute results.
// Handshake: no valid/ready pair; memStall=1 means the register holds its contents this edge,
// memStall=0 means the current inputs (or a bubble) are captured on the edge.
interface ex_mem_reg_if;
    import ex_mem_reg_pkg::*;

    logic [DATA_W-1:0] AluResIn, RtDataIn;
    logic              RegWriteIn, DMemWriteIn, DMemEnIn, MemToRegIn, DMemDumpIn;
    logic [REG_AW-1:0] RsAddrIn, RtAddrIn, RdAddrIn;
    logic              ValidIn, flush, memStall;

    logic [DATA_W-1:0] AluRes, RtIn;
    logic              RegWrite, DMemWrite, DMemEn, MemToReg, DMemDump;
    logic [REG_AW-1:0] RsAddr, RtAddr, RdAddr;
    logic              Valid, upStall, halted, wdErr;
    state_t            dbg_state;

    modport slave (
        input  AluResIn, RtDataIn, RegWriteIn, DMemWriteIn, DMemEnIn, MemToRegIn, DMemDumpIn,
        input  RsAddrIn, RtAddrIn, RdAddrIn, ValidIn, flush, memStall,
        output AluRes, RtIn, RegWrite, DMemWrite, DMemEn, MemToReg, DMemDump,
        output RsAddr, RtAddr, RdAddr, Valid, upStall, halted, wdErr, dbg_state
    );

    modport master (
        output AluResIn, RtDataIn, RegWriteIn, DMemWriteIn, DMemEnIn, MemToRegIn, DMemDumpIn,
        output RsAddrIn, RtAddrIn, RdAddrIn, ValidIn, flush, memStall,
        input  AluRes, RtIn, RegWrite, DMemWrite, DMemEn, MemToReg, DMemDump,
        input  RsAddr, RtAddr, RdAddr, Valid, upStall, halted, wdErr, dbg_state
    );

endinterface

// File: rtl/ex_mem_reg_stall_watchdog.sv
// Counts consecutive held cycles (saturating) and raises a sticky error once the
// count reaches STALL_LIMIT; the count clears whenever counting is not enabled.
module ex_mem_reg_stall_watchdog #(
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic err_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = (cnt_q >= LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
        end
        err_d = err_q | (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures execute results, freezes under memory stall,
// bubbles flushed and post-halt slots, and drives the upstream freeze.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = 7
) (
    input  logic         clk,
    input  logic         rst,
    ex_mem_reg_if.slave  bus
);

    state_t state_q, state_d;
    slot_t  slot_q, slot_d, in_slot;
    logic   flush_pend_q, flush_pend_d;
    logic   capture, bubble, wd_en, dump_leaving;

    assign dump_leaving = is_valid_dump(slot_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    // HALT is entered on the edge the dump instruction is handed on, never earlier.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN, HOLD: begin
                if (bus.memStall)      state_d = HOLD;
                else if (dump_leaving) state_d = HALT;
                else                   state_d = RUN;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        capture       = ~bus.memStall;
        wd_en         = bus.memStall & (state_q != HALT);
        bubble        = (state_q == HALT) | dump_leaving | bus.flush | flush_pend_q | ~bus.ValidIn;
        bus.upStall   = bus.memStall | (state_q == HALT);
        bus.halted    = (state_q == HALT);
        bus.dbg_state = state_q;
    end

    always_comb begin
        in_slot                = '0;
        in_slot.ctrl.RegWrite  = bus.RegWriteIn;
        in_slot.ctrl.DMemWrite = bus.DMemWriteIn;
        in_slot.ctrl.DMemEn    = bus.DMemEnIn;
        in_slot.ctrl.MemToReg  = bus.MemToRegIn;
        in_slot.ctrl.DMemDump  = bus.DMemDumpIn;
        in_slot.ctrl.Valid     = bus.ValidIn;
        in_slot.alu_res        = bus.AluResIn;
        in_slot.rt_data        = bus.RtDataIn;
        in_slot.rs_addr        = bus.RsAddrIn;
        in_slot.rt_addr        = bus.RtAddrIn;
        in_slot.rd_addr        = bus.RdAddrIn;
    end

    // A flush seen while held targets the slot that enters on release, not the held one.
    always_comb begin
        slot_d       = slot_q;
        flush_pend_d = flush_pend_q | bus.flush;
        if (capture) begin
            flush_pend_d = 1'b0;
            if (bubble) begin
                slot_d      = '0;
                slot_d.ctrl = BUBBLE_CTRL;
            end else begin
                slot_d = in_slot;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    ex_mem_reg_stall_watchdog #(
        .STALL_LIMIT (STALL_LIMIT),
        .CNT_W       (CNT_W)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .en_i  (wd_en),
        .err_o (bus.wdErr)
    );

    assign bus.AluRes    = slot_q.alu_res;
    assign bus.RtIn      = slot_q.rt_data;
    assign bus.RegWrite  = slot_q.ctrl.RegWrite;
    assign bus.DMemWrite = slot_q.ctrl.DMemWrite;
    assign bus.DMemEn    = slot_q.ctrl.DMemEn;
    assign bus.MemToReg  = slot_q.ctrl.MemToReg;
    assign bus.DMemDump  = slot_q.ctrl.DMemDump;
    assign bus.RsAddr    = slot_q.rs_addr;
    assign bus.RtAddr    = slot_q.rt_addr;
    assign bus.RdAddr    = slot_q.rd_addr;
    assign bus.Valid     = slot_q.ctrl.Valid;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios then randomized traffic, all checked against
// a slot-level reference model through an expected-value queue.
module tb_ex_mem_reg;
    import ex_mem_reg_pkg::*;

    localparam int LIMIT = 64;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] rt;
        logic        rw, dw, de, m2r, dump;
        logic [2:0]  rs, rta, rd;
        logic        v;
    } mslot_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    mslot_t      m_out;
    logic        m_halted, m_err, m_pend;
    int          m_stall_run;
    logic [48:0] exp_q[$];

    ex_mem_reg_if bus ();

    ex_mem_reg #(.STALL_LIMIT(LIMIT), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [48:0] obs_vec();
        return {bus.AluRes, bus.RtIn, bus.RegWrite, bus.DMemWrite, bus.DMemEn, bus.MemToReg,
                bus.DMemDump, bus.RsAddr, bus.RtAddr, bus.RdAddr, bus.Valid, bus.halted, bus.wdErr};
    endfunction

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_out       = '0;
        m_halted    = 1'b0;
        m_err       = 1'b0;
        m_pend      = 1'b0;
        m_stall_run = 0;
        exp_q.delete();
    endtask

    // One clock edge: a stalled edge holds; an accepted edge passes the dump on (halting)
    // and takes the incoming slot unless it is flushed, pending-flushed, invalid or post-halt.
    task automatic model_edge();
        if (bus.memStall) begin
            if (!m_halted) begin
                if (m_stall_run < 127) m_stall_run++;
                if (m_stall_run >= LIMIT) m_err = 1'b1;
            end
            m_pend = m_pend | bus.flush;
        end else begin
            m_stall_run = 0;
            if (m_halted || (m_out.v && m_out.dump)) begin
                m_halted = 1'b1;
                m_out    = '0;
            end else if (bus.flush || m_pend || !bus.ValidIn) begin
                m_out = '0;
            end else begin
                m_out.alu  = bus.AluResIn;
                m_out.rt   = bus.RtDataIn;
                m_out.rw   = bus.RegWriteIn;
                m_out.dw   = bus.DMemWriteIn;
                m_out.de   = bus.DMemEnIn;
                m_out.m2r  = bus.MemToRegIn;
                m_out.dump = bus.DMemDumpIn;
                m_out.rs   = bus.RsAddrIn;
                m_out.rta  = bus.RtAddrIn;
                m_out.rd   = bus.RdAddrIn;
                m_out.v    = bus.ValidIn;
            end
            m_pend = 1'b0;
        end
        exp_q.push_back({m_out, m_halted, m_err});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.AluResIn    = '0;
        bus.RtDataIn    = '0;
        bus.RegWriteIn  = 1'b0;
        bus.DMemWriteIn = 1'b0;
        bus.DMemEnIn    = 1'b0;
        bus.MemToRegIn  = 1'b0;
        bus.DMemDumpIn  = 1'b0;
        bus.RsAddrIn    = '0;
        bus.RtAddrIn    = '0;
        bus.RdAddrIn    = '0;
        bus.ValidIn     = 1'b0;
        bus.flush       = 1'b0;
        bus.memStall    = 1'b0;
    endtask

    task automatic drive_random(input int stall_pct, input int flush_pct, input int dump_pct);
        bus.AluResIn    = 16'($urandom);
        bus.RtDataIn    = 16'($urandom);
        bus.RegWriteIn  = 1'($urandom);
        bus.DMemWriteIn = 1'($urandom);
        bus.DMemEnIn    = 1'($urandom);
        bus.MemToRegIn  = 1'($urandom);
        bus.DMemDumpIn  = ($urandom_range(0, 99) < dump_pct);
        bus.RsAddrIn    = 3'($urandom);
        bus.RtAddrIn    = 3'($urandom);
        bus.RdAddrIn    = 3'($urandom);
        bus.ValidIn     = ($urandom_range(0, 99) < 80);
        bus.flush       = ($urandom_range(0, 99) < flush_pct);
        bus.memStall    = ($urandom_range(0, 99) < stall_pct);
    endtask

    // Inputs are set at the falling edge; outputs are compared at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("outputs", obs_vec(), exp_q.pop_front());
        check("upStall", bus.upStall, m_halted | bus.memStall);
    endtask

    task automatic do_reset();
        #1;
        rst          = 1'b0;
        bus.memStall = 1'b0;
        #1;
        check("rst_outputs", obs_vec(), '0);
        check("rst_upStall", bus.upStall, 1'b0);
        check("rst_state", bus.dbg_state, RUN);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        rst = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        check("por_outputs", obs_vec(), '0);
        rst = 1'b1;

        // pass-through
        bus.ValidIn = 1'b1; bus.AluResIn = 16'h1234; bus.RegWriteIn = 1'b1; bus.RdAddrIn = 3'd5;
        cycle();
        check("pt_alu", bus.AluRes, 16'h1234);
        check("pt_rd", bus.RdAddr, 3'd5);

        // stall with changing inputs, then release
        for (int i = 0; i < 3; i++) begin
            drive_random(100, 0, 0);
            bus.DMemDumpIn = 1'b0;
            cycle();
            check("stall_hold", bus.AluRes, 16'h1234);
        end
        drive_idle();
        bus.ValidIn = 1'b1; bus.AluResIn = 16'hBEEF;
        cycle();
        check("stall_release", bus.AluRes, 16'hBEEF);

        // flush during stall bubbles the slot entering on release
        bus.AluResIn = 16'h1111; bus.RegWriteIn = 1'b1;
        cycle();
        bus.memStall = 1'b1; bus.flush = 1'b1; bus.AluResIn = 16'h2222;
        cycle();
        bus.flush = 1'b0;
        cycle();
        check("flush_held", bus.AluRes, 16'h1111);
        bus.memStall = 1'b0;
        cycle();
        check("flush_valid", bus.Valid, 1'b0);
        check("flush_regwrite", bus.RegWrite, 1'b0);
        bus.AluResIn = 16'h3333;
        cycle();
        check("after_flush", bus.Valid, 1'b1);

        // watchdog
        bus.memStall = 1'b1;
        for (int i = 0; i < LIMIT - 1; i++) cycle();
        check("wd_before", bus.wdErr, 1'b0);
        cycle();
        check("wd_hit", bus.wdErr, 1'b1);
        bus.memStall = 1'b0;
        cycle();
        check("wd_sticky", bus.wdErr, 1'b1);

        // reset while held
        bus.memStall = 1'b1; bus.AluResIn = 16'h4444;
        repeat (2) cycle();
        do_reset();

        // halt after dump retires
        drive_idle();
        bus.ValidIn = 1'b1; bus.DMemDumpIn = 1'b1; bus.AluResIn = 16'h0D0D;
        cycle();
        check("dump_not_yet", bus.halted, 1'b0);
        bus.DMemDumpIn = 1'b0; bus.RegWriteIn = 1'b1; bus.AluResIn = 16'h5555;
        cycle();
        check("halted", bus.halted, 1'b1);
        check("halt_upstall", bus.upStall, 1'b1);
        check("halt_regwrite", bus.RegWrite, 1'b0);
        cycle();
        check("halt_regwrite2", bus.RegWrite, 1'b0);
        do_reset();

        // dump held under stall: halt waits for release
        drive_idle();
        bus.ValidIn = 1'b1; bus.DMemDumpIn = 1'b1;
        cycle();
        bus.DMemDumpIn = 1'b0; bus.memStall = 1'b1;
        repeat (2) cycle();
        check("dump_stalled", bus.halted, 1'b0);
        bus.memStall = 1'b0;
        cycle();
        check("dump_released", bus.halted, 1'b1);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 299) == 0) drive_random(100, 10, 0);
            else drive_random(25, 10, 2);
            if (bus.memStall && $urandom_range(0, 3) != 0) begin
                for (int j = 0; j < int'($urandom_range(1, 70)); j++) begin
                    bus.flush = ($urandom_range(0, 99) < 10);
                    cycle();
                end
            end else begin
                cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
